cipher_hs_ctrl: RTL

- Parametrised key/data handshake sequencer plus iterative round engine for the cipher datapath.
- Enforces the key-then-data protocol on Krdy/Drdy, gated by EN.
- Runs ROUNDS iterations of a simple round function and signals the result with a one-cycle Dvld pulse.
- Successor to the fixed-width handshake: generic width and round count, key reload, busy indication and protocol-error detection.

---
 rtl/cipher_hs_pkg.sv | 20 ++
 rtl/cipher_hs_round.sv | 16 +
 rtl/cipher_hs_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/cipher_hs_pkg.sv
// rtl/cipher_hs_pkg.sv - shared state encoding and round function for the cipher handshake block
package cipher_hs_pkg;

   typedef enum logic [1:0] {NOKEY, KEYED, RUN} state_t;

   // Widest datapath the round function can serve; callers pass their real width in w.
   localparam int MAX_W = 1024;

   function automatic logic [MAX_W-1:0] round_f(input logic [MAX_W-1:0] s,
                                                input logic [MAX_W-1:0] k,
                                                input logic [MAX_W-1:0] r,
                                                input int               w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] rot;
      mask = {MAX_W{1'b1}} >> (MAX_W - w);
      rot  = ((s << 1) | (s >> (w - 1))) & mask;
      return rot ^ k ^ r;
   endfunction

endpackage

// File: rtl/cipher_hs_round.sv
// rtl/cipher_hs_round.sv - one combinational round: rotl(s,1) ^ k ^ zero_ext(r)
module cipher_hs_round
   import cipher_hs_pkg::*;
#(
   parameter int W  = 128,
   parameter int CW = 4
) (
   input  logic [W-1:0]  s,
   input  logic [W-1:0]  k,
   input  logic [CW-1:0] r,
   output logic [W-1:0]  y
);

   assign y = W'(round_f(MAX_W'(s), MAX_W'(k), MAX_W'(r), W));

endmodule

// File: rtl/cipher_hs_ctrl.sv
// rtl/cipher_hs_ctrl.sv - key/data handshake sequencer with iterative round engine
// Optional ERR output and protocol checking enabled by CIPHER_HS_PROTOCOL_CHECK_EN.
module cipher_hs_ctrl
   import cipher_hs_pkg::*;
#(
   parameter int W      = 128,
   parameter int ROUNDS = 10
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic         Krdy,
   input  logic [W-1:0] Kin,
   input  logic         Drdy,
   input  logic [W-1:0] Din,
   output logic [W-1:0] Dout,
   output logic         Dvld,
   output logic         Kvld,
   output logic         BSY
`ifdef CIPHER_HS_PROTOCOL_CHECK_EN
   ,
   output logic         ERR
`endif
);

   localparam int CW = $clog2(ROUNDS + 1);

   state_t          state;
   logic [W-1:0]    key;
   logic [W-1:0]    st;
   logic [W-1:0]    nxt;
   logic [CW-1:0]   rc;

   cipher_hs_round #(.W(W), .CW(CW)) u_round (
      .s (st),
      .k (key),
      .r (rc),
      .y (nxt)
   );

`ifdef CIPHER_HS_PROTOCOL_CHECK_EN
   // Data without a key, data colliding with a key reload, or any strobe while busy.
   logic proto_err;
   assign proto_err = EN & (((state == NOKEY) & Drdy & ~Krdy) |
                            ((state == KEYED) & Drdy & Krdy) |
                            ((state == RUN) & (Drdy | Krdy)));
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= NOKEY;
         key   <= '0;
         st    <= '0;
         rc    <= '0;
         Dout  <= '0;
         Dvld  <= 1'b0;
         Kvld  <= 1'b0;
         BSY   <= 1'b0;
`ifdef CIPHER_HS_PROTOCOL_CHECK_EN
         ERR   <= 1'b0;
`endif
      end else if (!EN) begin
         Dvld <= 1'b0;
      end else begin
         Dvld <= 1'b0;
         case (state)
            NOKEY: begin
               if (Krdy) begin
                  key   <= Kin;
                  Kvld  <= 1'b1;
                  state <= KEYED;
               end
            end
            KEYED: begin
               if (Krdy) begin
                  key <= Kin;
               end else if (Drdy) begin
                  st    <= Din ^ key;
                  rc    <= '0;
                  BSY   <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (rc == CW'(ROUNDS - 1)) begin
                  Dout  <= nxt;
                  Dvld  <= 1'b1;
                  BSY   <= 1'b0;
                  rc    <= '0;
                  state <= KEYED;
               end else begin
                  st <= nxt;
                  rc <= rc + CW'(1);
               end
            end
            default: state <= NOKEY;
         endcase
`ifdef CIPHER_HS_PROTOCOL_CHECK_EN
         if (proto_err) ERR <= 1'b1;
`endif
      end
   end

endmodule
